// File: rtl/duty_cycle_meter_if.sv
// duty_cycle_meter_if: stimulus and result bundle for the duty cycle meter.
// master drives enable/sig_in; slave returns the measurement results.
interface duty_cycle_meter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period_count;
  logic [CNT_W-1:0] high_count;
  logic             meas_valid;
  logic             locked;
  logic             overflow;

  modport master (
    output enable,
    output sig_in,
    input  period_count,
    input  high_count,
    input  meas_valid,
    input  locked,
    input  overflow
  );

  modport slave (
    input  enable,
    input  sig_in,
    output period_count,
    output high_count,
    output meas_valid,
    output locked,
    output overflow
  );
endinterface

// File: rtl/duty_cycle_meter.sv
// duty_cycle_meter: measures period and high time of a slow signal
// in reference clock cycles, with sticky overflow and lock tracking.
module duty_cycle_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                clock,
  input logic                reset,
  duty_cycle_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = '1;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise;

  logic [CNT_W-1:0] per_cnt, per_cnt_n;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic [CNT_W-1:0] high_q, high_n;
  logic valid_q, valid_n;
  logic locked_q, locked_n;
  logic ovf_q, ovf_n;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
      s_d  <= s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      per_cnt  <= per_cnt_n;
      hi_cnt   <= hi_cnt_n;
      period_q <= period_n;
      high_q   <= high_n;
      valid_q  <= valid_n;
      locked_q <= locked_n;
      ovf_q    <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    per_cnt_n = per_cnt;
    hi_cnt_n  = hi_cnt;
    period_n  = period_q;
    high_n    = high_q;
    valid_n   = 1'b0;
    locked_n  = locked_q;
    ovf_n     = ovf_q;
    // Dropping enable aborts everything except the last result.
    if (!bus.enable) begin
      state_n   = IDLE;
      per_cnt_n = '0;
      hi_cnt_n  = '0;
      locked_n  = 1'b0;
      ovf_n     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          per_cnt_n = '0;
          hi_cnt_n  = '0;
          state_n   = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            per_cnt_n = ONE;
            hi_cnt_n  = ONE;
            state_n   = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n  = per_cnt;
            high_n    = hi_cnt;
            valid_n   = 1'b1;
            locked_n  = 1'b1;
            per_cnt_n = ONE;
            hi_cnt_n  = ONE;
          end else if (per_cnt == FULL) begin
            ovf_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = WAIT_RISE;
          end else begin
            per_cnt_n = per_cnt + ONE;
            if (s) hi_cnt_n = hi_cnt + ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.period_count = period_q;
  assign bus.high_count   = high_q;
  assign bus.meas_valid   = valid_q;
  assign bus.locked       = locked_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// tb_duty_cycle_meter: random and directed patterns checked against
// a timestamp-based reference of rise times and high-cycle sums.
module tb_duty_cycle_meter;

  localparam int CW   = 8;
  localparam int MAXC = 255;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  duty_cycle_meter_if #(.CNT_W(CW)) dif ();

  duty_cycle_meter #(
    .CNT_W(CW),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(dif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: cycle index, input history, last counted rise time.
  int t;
  bit hist[$];
  bit armed;
  int t0;
  logic [CW-1:0] e_per, e_hi;
  logic e_val, e_lock, e_ovf;

  logic [2*CW+2:0] got, expv;
  assign got  = {dif.period_count, dif.high_count,
                 dif.meas_valid, dif.locked, dif.overflow};
  assign expv = {e_per, e_hi, e_val, e_lock, e_ovf};

  // Synchronized level seen by the meter during cycle k.
  function automatic bit s_of(int k);
    if (k < 2 || k - 2 >= hist.size()) return 1'b0;
    return hist[k-2];
  endfunction

  task automatic clear_model();
    t = 0;
    hist.delete();
    armed = 0;
    t0 = -1;
    e_per = '0; e_hi = '0;
    e_val = 0; e_lock = 0; e_ovf = 0;
  endtask

  task automatic step(input bit si, input bit en);
    bit rise;
    int hi;
    dif.sig_in = si;
    dif.enable = en;
    hist.push_back(si);
    rise = s_of(t) && !s_of(t - 1);
    e_val = 0;
    if (!en) begin
      armed = 0; t0 = -1; e_lock = 0; e_ovf = 0;
    end else if (!armed) begin
      armed = 1;
    end else if (t0 < 0) begin
      if (rise) t0 = t;
    end else if (rise) begin
      hi = 0;
      for (int k = t0; k < t; k++) hi += s_of(k);
      e_per = CW'(t - t0);
      e_hi = CW'(hi);
      e_val = 1; e_lock = 1;
      t0 = t;
    end else if (t - t0 == MAXC) begin
      e_ovf = 1; e_lock = 0; t0 = -1;
    end
    t++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dif.sig_in = 1'b1;
    dif.enable = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    n_chk++;
    if (dif.period_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_period got=%h exp=0", dif.period_count);
    end
    n_chk++;
    if (dif.high_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_high got=%h exp=0", dif.high_count);
    end
    n_chk++;
    if (dif.meas_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got=%b exp=0", dif.meas_valid);
    end
    n_chk++;
    if (dif.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_locked got=%b exp=0", dif.locked);
    end
    n_chk++;
    if (dif.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ovf got=%b exp=0", dif.overflow);
    end
  endtask

  task automatic test_pattern(input int hi, input int lo,
                              input int periods, input string nm);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < hi + lo; i++) begin
        step(i < hi, 1'b1);
        n_chk++;
        if (got !== expv) begin
          n_fail++;
          $display("FAIL %s t=%0d got=%h exp=%h", nm, t, got, expv);
        end
      end
    end
    n_chk++;
    if (dif.locked !== 1'b1 || dif.period_count !== CW'(hi + lo) ||
        dif.high_count !== CW'(hi)) begin
      n_fail++;
      $display("FAIL %s_final got=%b/%0d/%0d exp=1/%0d/%0d", nm,
               dif.locked, dif.period_count, dif.high_count,
               hi + lo, hi);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3 + MAXC + 10; i++) begin
      step(i < 3, 1'b1);
      n_chk++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL ovf t=%0d got=%h exp=%h", t, got, expv);
      end
    end
    n_chk++;
    if (dif.overflow !== 1'b1 || dif.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_final got=%b%b exp=10",
               dif.overflow, dif.locked);
    end
  endtask

  task automatic test_enable_abort();
    int nv;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    n_chk++;
    if (dif.locked !== 1'b0 || dif.overflow !== 1'b0 ||
        got !== expv) begin
      n_fail++;
      $display("FAIL abort got=%h exp=%h", got, expv);
    end
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(i % 8 < 4, 1'b1);
      nv += int'(dif.meas_valid);
      n_chk++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL abort_run t=%0d got=%h exp=%h", t, got, expv);
      end
    end
    n_chk++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL abort_valids got=%0d exp=0", nv);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    do_reset();
    n_chk++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h exp=0", got);
    end
  endtask

  task automatic test_random();
    int hi, lo;
    bit en;
    for (int p = 0; p < 40; p++) begin
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      for (int i = 0; i < hi + lo; i++) begin
        en = ($urandom_range(0, 40) != 0);
        step(i < hi, en);
        n_chk++;
        if (got !== expv) begin
          n_fail++;
          $display("FAIL rand t=%0d got=%h exp=%h", t, got, expv);
        end
      end
    end
  endtask

  initial begin
    dif.enable = 1'b0;
    dif.sig_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    do_reset();
    test_reset();
    test_pattern(4, 4, 3, "p44");
    test_pattern(1, 5, 3, "p15");
    test_pattern(5, 1, 3, "p51");
    test_overflow();
    test_enable_abort();
    test_pattern(4, 4, 3, "p44_resume");
    test_reset_mid();
    test_pattern(4, 4, 3, "p44_after_rst");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
